mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MEM stage of the pipelined CPU, directly downstream of the EXE/MEM register.
- Consumes the EXE/MEM register outputs and runs loads and stores on a data-memory port with a valid/ready handshake.
- Stalls the upstream pipeline while an access is outstanding.
- Registers write-back data, destination and enable as the MEM/WB boundary.

Parameters:
- ADDR_W, 32, data-memory address width (low ADDR_W bits of ALURes)
- DATA_W, 32, datapath width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  EXE/MEM slot holds a real instruction (0 = bubble)
- DataMemWE  in  1  store request
- WriteDataSrc  in  WDATA_SRC_LENGTH  write-back source select (WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01; other codes treated as ALU)
- ALURes  in  DATA_W  effective address / ALU result
- Reg2DataOut  in  DATA_W  store data
- WriteRegSrc  in  5  destination register
- RegWE  in  1  register write enable
- mem_req  out  1  memory request valid
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepted/completed this cycle; rdata valid when read
- mem_rdata  in  DATA_W  read data
- stall  out  1  hold IF..EXE/MEM this cycle
- WriteData_out  out  DATA_W  write-back value
- WriteRegSrc_out  out  5  write-back destination
- RegWE_out  out  1  write-back enable
- valid_out  out  1  MEM/WB slot valid

Behaviour:
- is_mem = in_valid & (DataMemWE | WriteDataSrc==WB_SRC_MEM).
- FSM states: IDLE, ACCESS.
- IDLE, is_mem=1:
  - Capture addr = ALURes[ADDR_W-1:0], wdata = Reg2DataOut, we = DataMemWE, plus dest and RegWE.
  - Go to ACCESS.
  - Store with WB_SRC_MEM counts as a store: we=1, no read.
- IDLE, is_mem=0: stay in IDLE.
- ACCESS: on mem_ready=1 go to IDLE; otherwise stay.
- mem_req, mem_we, mem_addr and mem_wdata are registered. mem_req is high for every cycle in ACCESS and low in IDLE.
- Address and data stay stable while mem_req=1.
- stall (combinational) = (IDLE & is_mem) | (ACCESS & ~mem_ready).
- Non-memory instructions: 1-cycle latency. The next edge loads WriteData_out=ALURes, WriteRegSrc_out, RegWE_out, valid_out=in_valid.
- Memory instructions, on the ACCESS edge where mem_ready=1:
  - valid_out=1.
  - Load: WriteData_out=mem_rdata.
  - Store: WriteData_out=captured address.
  - RegWE_out=captured RegWE.
  - Minimum latency is 2 cycles (zero-wait memory).
- In every other ACCESS cycle, and in the IDLE cycle that launches an access, a bubble is inserted: valid_out=0, RegWE_out=0.
- RegWE_out is forced to 0 when the destination is register 0 or valid_out=0.
- mem_ready while in IDLE is ignored.
- Upstream holds its inputs while stall=1. The stage relies only on its captured copies during ACCESS.
- Reset (rst=0, any state, including mid-access):
  - state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - WriteData_out=0, WriteRegSrc_out=0, RegWE_out=0, valid_out=0.
  - A pending access is abandoned; a late mem_ready is ignored.
- Back-to-back memory instructions:
  - The IDLE cycle after completion launches the next access.
  - One stall cycle is inserted per access even with zero-wait memory.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - An access with addr[1:0]!=0 is not issued: no mem_req, no ACCESS, no stall beyond the IDLE evaluation cycle.
  - It completes next edge with RegWE_out=0, valid_out=1, and an extra output port misalign_out=1 for that one cycle.
  - misalign_out resets to 0.
- MEM_ALIGN_CHECK_EN undefined: the port is absent and addresses are issued unchecked.

Decomposition:
- Shared const.vh holds WDATA_SRC_LENGTH, WB_SRC_ALU, WB_SRC_MEM, INIT_32 and the state encodings MEM_IDLE and MEM_ACCESS.
- One sub-module is natural: mem_wb_reg, the MEM/WB output register with bubble and reg-0 masking.
- The FSM and handshake stay in mem_stage.

Test Plan:
- ALU op, ALURes=0x0000_1234, WriteRegSrc=5, RegWE=1 -> next cycle: WriteData_out=0x1234, RegWE_out=1, valid_out=1, stall never high.
- Load, ALURes=0x100, mem_ready delayed 3 cycles, mem_rdata=0xDEADBEEF:
  - mem_req high for exactly 3 cycles with mem_addr=0x100.
  - stall high 3 cycles.
  - Then WriteData_out=0xDEADBEEF, RegWE_out=1.
- Store, ALURes=0x200, Reg2DataOut=0xCAFEF00D, zero-wait memory -> one mem_req cycle with mem_we=1, mem_wdata=0xCAFEF00D; RegWE_out=0 when RegWE=0.
- Two back-to-back loads, zero-wait -> two distinct mem_req cycles separated by one IDLE cycle; valid_out pattern 0,1,0,1.
- rst=0 asserted while in ACCESS with mem_ready=0, then mem_ready=1 after release -> all outputs 0, state IDLE, no write-back.
- ALU op with WriteRegSrc=0, RegWE=1 -> RegWE_out=0.
- With MEM_ALIGN_CHECK_EN, load at 0x102 -> no mem_req; misalign_out=1, RegWE_out=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and FSM encoding for the MEM stage.
package mem_stage_pkg;
  localparam int WDATA_SRC_LENGTH = 2;
  localparam logic [WDATA_SRC_LENGTH-1:0] WB_SRC_ALU = 2'b00;
  localparam logic [WDATA_SRC_LENGTH-1:0] WB_SRC_MEM = 2'b01;
  localparam logic [31:0] INIT_32 = 32'h0000_0000;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB boundary register: bubbles and writes to register 0 never enable write-back.
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [4:0]        i_dest,
  input  logic              i_regwe,
  output logic [DATA_W-1:0] o_data,
  output logic [4:0]        o_dest,
  output logic              o_regwe,
  output logic              o_valid
);
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_dest;
  logic              r_regwe;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data  <= '0;
      r_dest  <= '0;
      r_regwe <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_data  <= i_data;
      r_dest  <= i_dest;
      r_regwe <= i_regwe & i_valid & (|i_dest);
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_dest  = r_dest;
  assign o_regwe = r_regwe;
  assign o_valid = r_valid;
endmodule

// File: rtl/mem_stage.sv
// MEM stage: valid/ready data-memory access FSM with upstream stall and MEM/WB register.
// Optional: MEM_ALIGN_CHECK_EN retires misaligned accesses without issuing them (adds misalign_out).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        DataMemWE,
  input  logic [WDATA_SRC_LENGTH-1:0] WriteDataSrc,
  input  logic [DATA_W-1:0]           ALURes,
  input  logic [DATA_W-1:0]           Reg2DataOut,
  input  logic [4:0]                  WriteRegSrc,
  input  logic                        RegWE,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_ready,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        stall,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                        misalign_out,
`endif
  output logic [DATA_W-1:0]           WriteData_out,
  output logic [4:0]                  WriteRegSrc_out,
  output logic                        RegWE_out,
  output logic                        valid_out
);
  mem_state_t        r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [4:0]        r_dest;
  logic              r_regwe;

  logic              w_is_mem;
  logic              w_misalign;
  logic              w_launch;
  logic              w_wb_valid;
  logic [DATA_W-1:0] w_wb_data;
  logic [4:0]        w_wb_dest;
  logic              w_wb_regwe;

  assign w_is_mem = in_valid & (DataMemWE | (WriteDataSrc == WB_SRC_MEM));
`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_is_mem & (|ALURes[1:0]);
`else
  assign w_misalign = 1'b0;
`endif
  assign w_launch = (r_state == MEM_IDLE) & w_is_mem & ~w_misalign;
  assign stall    = w_launch | ((r_state == MEM_ACCESS) & ~mem_ready);

  // A store that also selects the memory source is still just a store (we wins).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= MEM_IDLE;
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_dest    <= '0;
      r_regwe   <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_launch) begin
            r_state   <= MEM_ACCESS;
            r_mem_req <= 1'b1;
            r_mem_we  <= DataMemWE;
            r_addr    <= ALURes[ADDR_W-1:0];
            r_wdata   <= Reg2DataOut;
            r_dest    <= WriteRegSrc;
            r_regwe   <= RegWE;
          end
        end
        MEM_ACCESS: begin
          if (mem_ready) begin
            r_state   <= MEM_IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  // Launch cycles and waiting ACCESS cycles retire a bubble.
  always_comb begin
    w_wb_valid = 1'b0;
    w_wb_data  = ALURes;
    w_wb_dest  = WriteRegSrc;
    w_wb_regwe = RegWE;
    if (r_state == MEM_ACCESS) begin
      w_wb_valid = mem_ready;
      w_wb_data  = r_mem_we ? DATA_W'(r_addr) : mem_rdata;
      w_wb_dest  = r_dest;
      w_wb_regwe = r_regwe;
    end else if (!w_launch) begin
      w_wb_valid = in_valid;
      w_wb_regwe = RegWE & ~w_misalign;
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_wb (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_wb_valid),
    .i_data  (w_wb_data),
    .i_dest  (w_wb_dest),
    .i_regwe (w_wb_regwe),
    .o_data  (WriteData_out),
    .o_dest  (WriteRegSrc_out),
    .o_regwe (RegWE_out),
    .o_valid (valid_out)
  );

`ifdef MEM_ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (!rst) r_misalign <= 1'b0;
    else      r_misalign <= (r_state == MEM_IDLE) & w_misalign;
  end
  assign misalign_out = r_misalign;
`endif
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level expectation model.
module tb_mem_stage;
  localparam int K_ALU = 0, K_LD = 1, K_ST = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, DataMemWE = 1'b0, RegWE = 1'b0;
  logic [1:0]  WriteDataSrc = 2'b00;
  logic [31:0] ALURes = '0, Reg2DataOut = '0, mem_rdata = '0;
  logic [4:0]  WriteRegSrc = '0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, stall, RegWE_out, valid_out;
  logic [31:0] mem_addr, mem_wdata, WriteData_out;
  logic [4:0]  WriteRegSrc_out;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_out;
`endif

  int n_tests = 0, n_fail = 0;

  mem_stage #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .DataMemWE(DataMemWE),
    .WriteDataSrc(WriteDataSrc), .ALURes(ALURes), .Reg2DataOut(Reg2DataOut),
    .WriteRegSrc(WriteRegSrc), .RegWE(RegWE), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall(stall),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_out(misalign_out),
`endif
    .WriteData_out(WriteData_out), .WriteRegSrc_out(WriteRegSrc_out),
    .RegWE_out(RegWE_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  // Drives one instruction from a negedge, plays the memory with nwait wait cycles,
  // and reports what was observed; returns at the negedge after write-back.
  task automatic do_op(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] dest, input logic rwe, input int nwait,
                       input logic [31:0] rd,
                       output int req_cyc, output int stall_cyc, output int bad_cyc,
                       output logic [31:0] a_seen, output logic [31:0] wd_seen,
                       output logic we_seen, output logic [31:0] wb_d,
                       output logic wb_we, output logic wb_v);
    logic [1:0] alu_src [3];
    alu_src[0] = 2'b00; alu_src[1] = 2'b10; alu_src[2] = 2'b11;
    in_valid    = 1'b1;
    DataMemWE   = (kind == K_ST);
    WriteDataSrc = (kind == K_LD) ? 2'b01 :
                   (kind == K_ST) ? 2'($urandom_range(0, 1)) : alu_src[$urandom_range(0, 2)];
    ALURes = addr; Reg2DataOut = wd; WriteRegSrc = dest; RegWE = rwe; mem_ready = 1'b0;
    req_cyc = 0; stall_cyc = 0; bad_cyc = 0;
    a_seen = '0; wd_seen = '0; we_seen = 1'b0;
    #1 if (stall) stall_cyc++;
    @(negedge clk);
    for (int c = 0; c < 64 && mem_req; c++) begin
      if (req_cyc == 0) begin
        a_seen = mem_addr; wd_seen = mem_wdata; we_seen = mem_we;
      end else if (mem_addr !== a_seen || mem_wdata !== wd_seen || mem_we !== we_seen) begin
        bad_cyc++;
      end
      if (valid_out !== 1'b0 || RegWE_out !== 1'b0) bad_cyc++;
      req_cyc++;
      if (c == nwait) begin
        mem_ready = 1'b1; mem_rdata = rd;
      end else begin
        mem_rdata = $urandom;
      end
      #1 if (stall) stall_cyc++;
      @(negedge clk);
      mem_ready = 1'b0;
    end
    wb_d = WriteData_out; wb_we = RegWE_out; wb_v = valid_out;
  endtask

  int r, s, b;
  logic [31:0] a, w, d;
  logic we, ow, ov;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, stall, WriteData_out, WriteRegSrc_out, RegWE_out, valid_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b addr=%h wdata=%h stall=%b wd=%h dst=%0d rwe=%b v=%b, want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, stall, WriteData_out, WriteRegSrc_out, RegWE_out, valid_out);
    end
    rst = 1'b1;
  endtask

  task automatic test_alu;
    do_op(K_ALU, 32'h0000_1234, $urandom, 5'd5, 1'b1, 0, 0, r, s, b, a, w, we, d, ow, ov);
    n_tests++;
    if (s !== 0 || r !== 0) begin n_fail++; $display("FAIL alu_stall: stall_cyc=%0d req_cyc=%0d want 0 0", s, r); end
    n_tests++;
    if ({d, ow, ov} !== {32'h1234, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL alu_wb: wd=%h rwe=%b v=%b want 00001234 1 1", d, ow, ov);
    end
  endtask

  task automatic test_load_wait;
    do_op(K_LD, 32'h100, $urandom, 5'd7, 1'b1, 2, 32'hDEADBEEF, r, s, b, a, w, we, d, ow, ov);
    n_tests++;
    if (r !== 3 || s !== 3 || b !== 0) begin
      n_fail++; $display("FAIL load_wait_cycles: req=%0d stall=%0d bad=%0d want 3 3 0", r, s, b);
    end
    n_tests++;
    if (a !== 32'h100 || we !== 1'b0) begin n_fail++; $display("FAIL load_addr: addr=%h we=%b want 00000100 0", a, we); end
    n_tests++;
    if ({d, ow, ov} !== {32'hDEADBEEF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL load_wb: wd=%h rwe=%b v=%b want deadbeef 1 1", d, ow, ov);
    end
  endtask

  task automatic test_store;
    do_op(K_ST, 32'h200, 32'hCAFEF00D, 5'd9, 1'b0, 0, $urandom, r, s, b, a, w, we, d, ow, ov);
    n_tests++;
    if (r !== 1 || s !== 1 || b !== 0) begin
      n_fail++; $display("FAIL store_cycles: req=%0d stall=%0d bad=%0d want 1 1 0", r, s, b);
    end
    n_tests++;
    if (a !== 32'h200 || we !== 1'b1 || w !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL store_bus: addr=%h we=%b wdata=%h want 00000200 1 cafef00d", a, we, w);
    end
    n_tests++;
    if ({d, ow, ov} !== {32'h200, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL store_wb: wd=%h rwe=%b v=%b want 00000200 0 1", d, ow, ov);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] ad, rdv;
      ad = 32'h300 + 32'(k * 4); rdv = $urandom;
      do_op(K_LD, ad, $urandom, 5'd3, 1'b1, 0, rdv, r, s, b, a, w, we, d, ow, ov);
      n_tests++;
      if (r !== 1 || s !== 1 || b !== 0 || a !== ad) begin
        n_fail++; $display("FAIL b2b_access%0d: req=%0d stall=%0d bad=%0d addr=%h want 1 1 0 %h", k, r, s, b, a, ad);
      end
      n_tests++;
      if ({d, ow, ov} !== {rdv, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL b2b_wb%0d: wd=%h rwe=%b v=%b want %h 1 1", k, d, ow, ov, rdv);
      end
    end
  endtask

  task automatic test_reset_mid_access;
    in_valid = 1'b1; DataMemWE = 1'b0; WriteDataSrc = 2'b01; ALURes = 32'h400;
    WriteRegSrc = 5'd4; RegWE = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_mid_setup: req=%b want 1", mem_req); end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    n_tests++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, WriteData_out, WriteRegSrc_out, RegWE_out, valid_out} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: req=%b addr=%h wd=%h v=%b rwe=%b want all 0",
                         mem_req, mem_addr, WriteData_out, valid_out, RegWE_out);
    end
    #1 n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: stall=%b want 0", stall); end
    mem_ready = 1'b1; mem_rdata = $urandom;
    @(negedge clk);
    mem_ready = 1'b0;
    n_tests++;
    if (mem_req !== 1'b0 || valid_out !== 1'b0 || RegWE_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_late_ready: req=%b v=%b rwe=%b want 0 0 0", mem_req, valid_out, RegWE_out);
    end
  endtask

  task automatic test_reg0;
    do_op(K_ALU, $urandom, $urandom, 5'd0, 1'b1, 0, 0, r, s, b, a, w, we, d, ow, ov);
    n_tests++;
    if (ow !== 1'b0 || ov !== 1'b1) begin n_fail++; $display("FAIL reg0_mask: rwe=%b v=%b want 0 1", ow, ov); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 40; k++) begin
      int kind, nw;
      logic [31:0] ad, wdv, rdv, exp_d;
      logic [4:0] dst;
      logic rw;
      kind = $urandom_range(0, 2); nw = $urandom_range(0, 3);
      ad = $urandom; if (kind != K_ALU) ad[1:0] = 2'b00;
      wdv = $urandom; rdv = $urandom; dst = 5'($urandom); rw = 1'($urandom);
      do_op(kind, ad, wdv, dst, rw, nw, rdv, r, s, b, a, w, we, d, ow, ov);
      exp_d = (kind == K_LD) ? rdv : ad;
      n_tests++;
      if (kind == K_ALU ? (r !== 0 || s !== 0) : (r !== nw + 1 || s !== nw + 1 || b !== 0)) begin
        n_fail++; $display("FAIL rand%0d_timing: kind=%0d req=%0d stall=%0d bad=%0d nwait=%0d", k, kind, r, s, b, nw);
      end
      n_tests++;
      if (kind != K_ALU && (a !== ad || we !== (kind == K_ST) || (kind == K_ST && w !== wdv))) begin
        n_fail++; $display("FAIL rand%0d_bus: addr=%h we=%b wdata=%h want %h %b %h", k, a, we, w, ad, kind == K_ST, wdv);
      end
      n_tests++;
      if ({d, ow, ov} !== {exp_d, rw & (dst != 0), 1'b1}) begin
        n_fail++; $display("FAIL rand%0d_wb: wd=%h rwe=%b v=%b want %h %b 1", k, d, ow, ov, exp_d, rw & (dst != 0));
      end
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (valid_out !== 1'b0 || RegWE_out !== 1'b0) begin
          n_fail++; $display("FAIL rand%0d_bubble: v=%b rwe=%b want 0 0", k, valid_out, RegWE_out);
        end
      end
    end
  endtask

`ifdef MEM_ALIGN_CHECK_EN
  task automatic test_misalign;
    in_valid = 1'b1; DataMemWE = 1'b0; WriteDataSrc = 2'b01; ALURes = 32'h102;
    WriteRegSrc = 5'd6; RegWE = 1'b1; mem_ready = 1'b0;
    #1 n_tests++;
    if (stall !== 1'b0) begin n_fail++; $display("FAIL misalign_stall: stall=%b want 0", stall); end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if ({mem_req, misalign_out, RegWE_out, valid_out} !== 4'b0101) begin
      n_fail++; $display("FAIL misalign_wb: req=%b mis=%b rwe=%b v=%b want 0 1 0 1", mem_req, misalign_out, RegWE_out, valid_out);
    end
    @(negedge clk);
    n_tests++;
    if (misalign_out !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++; $display("FAIL misalign_pulse: mis=%b req=%b want 0 0", misalign_out, mem_req);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_alu;
    test_load_wait;
    test_store;
    test_back_to_back;
    test_reset_mid_access;
    test_reg0;
`ifdef MEM_ALIGN_CHECK_EN
    test_misalign;
`endif
    test_random;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
